// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: valid/ready/data channel; master drives valid+data, slave drives ready
interface pipe_stage_elastic_if #(
  parameter int WIDTH = 158
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: DEPTH-deep elastic pipeline latch with valid/ready stall, bubble collapse, flush and occupancy count; ports clk, clr (async reset), flush, prod (in_valid/in_ready/in_data), cons (out_valid/out_ready/out_data), count
module pipe_stage_elastic #(
  parameter int WIDTH       = 158,
  parameter int DEPTH       = 1,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  prod,
  pipe_stage_elastic_if.master cons,
  output logic [CW-1:0]        count
);
  logic [DEPTH-1:0]            v, nv, rdy;
  logic [DEPTH-1:0][WIDTH-1:0] d, nd;
  logic [DEPTH:0]              sv;
  logic [DEPTH:0][WIDTH-1:0]   sd;
  logic [CW-1:0]               nc;
  assign sv = {v, prod.valid};
  assign sd = {d, prod.data};
  assign prod.ready = rdy[0] & ~flush;
  assign cons.valid = v[DEPTH-1];
  assign cons.data  = v[DEPTH-1] || !ZERO_BUBBLE ? d[DEPTH-1] : '0;
  always_comb begin
    logic go;
    rdy = '0;
    nv  = '0;
    nd  = '0;
    nc  = '0;
    go  = cons.ready;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      go     = go | ~v[j];
      rdy[j] = go;
      nv[j]  = !flush && (go ? sv[j] : v[j]);
      nd[j]  = flush ? '0 : go ? sd[j] : d[j];
      nc     = nc + CW'(nv[j]);
    end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      v     <= '0;
      d     <= '0;
      count <= '0;
    end else begin
      v     <= nv;
      d     <= nd;
      count <= nc;
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed and randomized checks of four pipe_stage_elastic configurations against a slot-queue model
module tb_pipe_stage_elastic;
  localparam int W = 158;
  localparam int DEP [4] = '{3, 2, 1, 3};
  logic clk = 1'b0, clr = 1'b1, flush = 1'b0;
  logic iv [4], ordy [4], irdy [4], ov [4];
  logic [W-1:0] id [4], od [4];
  int cnt [4];
  logic [1:0] cnt_a, cnt_b, cnt_z;
  logic cnt_c;
  logic mv [4][3];
  logic [W-1:0] md [4][3];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  pipe_stage_elastic_if #(.WIDTH(W)) pa (), ca (), pb (), cb (), pc (), cc (), pz (), cz ();
  pipe_stage_elastic #(.WIDTH(W), .DEPTH(3), .ZERO_BUBBLE(1'b1)) dut_a (.clk(clk), .clr(clr), .flush(flush), .prod(pa), .cons(ca), .count(cnt_a));
  pipe_stage_elastic #(.WIDTH(W), .DEPTH(2), .ZERO_BUBBLE(1'b1)) dut_b (.clk(clk), .clr(clr), .flush(flush), .prod(pb), .cons(cb), .count(cnt_b));
  pipe_stage_elastic #(.WIDTH(W), .DEPTH(1), .ZERO_BUBBLE(1'b1)) dut_c (.clk(clk), .clr(clr), .flush(flush), .prod(pc), .cons(cc), .count(cnt_c));
  pipe_stage_elastic #(.WIDTH(W), .DEPTH(3), .ZERO_BUBBLE(1'b0)) dut_z (.clk(clk), .clr(clr), .flush(flush), .prod(pz), .cons(cz), .count(cnt_z));
  assign pa.valid = iv[0];
  assign pa.data  = id[0];
  assign ca.ready = ordy[0];
  assign irdy[0]  = pa.ready;
  assign ov[0]    = ca.valid;
  assign od[0]    = ca.data;
  assign cnt[0]   = int'(cnt_a);
  assign pb.valid = iv[1];
  assign pb.data  = id[1];
  assign cb.ready = ordy[1];
  assign irdy[1]  = pb.ready;
  assign ov[1]    = cb.valid;
  assign od[1]    = cb.data;
  assign cnt[1]   = int'(cnt_b);
  assign pc.valid = iv[2];
  assign pc.data  = id[2];
  assign cc.ready = ordy[2];
  assign irdy[2]  = pc.ready;
  assign ov[2]    = cc.valid;
  assign od[2]    = cc.data;
  assign cnt[2]   = int'(cnt_c);
  assign pz.valid = iv[3];
  assign pz.data  = id[3];
  assign cz.ready = ordy[3];
  assign irdy[3]  = pz.ready;
  assign ov[3]    = cz.valid;
  assign od[3]    = cz.data;
  assign cnt[3]   = int'(cnt_z);

  function automatic int mcnt(int k);
    int n = 0;
    for (int i = 0; i < DEP[k]; i++) n += int'(mv[k][i]);
    return n;
  endfunction

  function automatic logic exp_rdy(int k);
    return !flush && (mcnt(k) < DEP[k] || ordy[k]);
  endfunction

  function automatic logic mlast(int k);
    return mv[k][DEP[k]-1];
  endfunction

  function automatic logic [W-1:0] mout(int k);
    return mv[k][DEP[k]-1] ? md[k][DEP[k]-1] : '0;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 3; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = '0;
      end
  endtask

  // entries slide toward the output whenever the slot ahead is free; the output slot empties on a take
  task automatic model_edge;
    logic acc [4];
    for (int k = 0; k < 4; k++) acc[k] = iv[k] && exp_rdy(k);
    for (int k = 0; k < 4; k++) begin
      if (flush) begin
        for (int i = 0; i < 3; i++) mv[k][i] = 1'b0;
      end else begin
        if (ordy[k]) mv[k][DEP[k]-1] = 1'b0;
        for (int i = DEP[k] - 2; i >= 0; i--)
          if (mv[k][i] && !mv[k][i+1]) begin
            mv[k][i+1] = 1'b1;
            md[k][i+1] = md[k][i];
            mv[k][i]   = 1'b0;
          end
        if (acc[k]) begin
          mv[k][0] = 1'b1;
          md[k][0] = id[k];
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    if (!clr) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (ov[k] !== 1'b0 || od[k] !== '0 || cnt[k] !== 0 || irdy[k] !== 1'b1) begin
        nerr++;
        $display("FAIL reset_state dut%0d: valid=%b data=%h count=%0d in_ready=%b, want 0 0 0 1", k, ov[k], od[k], cnt[k], irdy[k]);
      end
    end
    @(negedge clk);
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id[0] = W'(i);
      tick();
    end
    iv[0] = 1'b0;
    nvec++;
    if (cnt[0] !== 3 || ov[0] !== 1'b1 || od[0] !== W'(1)) begin
      nerr++;
      $display("FAIL reset_fill: count=%0d valid=%b data=%h, want 3 1 1", cnt[0], ov[0], od[0]);
    end
    #2 clr = 1'b1;
    #1;
    nvec++;
    if (ov[0] !== 1'b0 || od[0] !== '0 || cnt[0] !== 0) begin
      nerr++;
      $display("FAIL reset_async: valid=%b data=%h count=%0d, want 0 0 0", ov[0], od[0], cnt[0]);
    end
    model_clear();
    #1 clr = 1'b0;
    ordy[0] = 1'b1;
    tick();
    nvec++;
    if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: in_ready=%b valid=%b, want 1 0", irdy[0], ov[0]);
    end
  endtask

  task automatic test_stream;
    logic [7:0] sd [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] eo [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    int ec [6] = '{1, 2, 3, 2, 1, 0};
    ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      iv[0] = c < 3;
      id[0] = W'(sd[c % 3]);
      tick();
      nvec++;
      if (od[0] !== W'(eo[c]) || ov[0] !== (eo[c] != 8'h00) || cnt[0] !== ec[c]) begin
        nerr++;
        $display("FAIL stream cycle%0d: data=%h valid=%b count=%0d, want %h %b %0d", c, od[0], ov[0], cnt[0], eo[c], eo[c] != 8'h00, ec[c]);
      end
    end
    iv[0] = 1'b0;
  endtask

  task automatic test_stall;
    logic [W-1:0] got [$];
    logic acc;
    logic ok;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    id[0] = W'(8'hA1);
    #1;
    nvec++;
    if (irdy[0] !== 1'b1) begin
      nerr++;
      $display("FAIL stall_first_ready: in_ready=%b, want 1", irdy[0]);
    end
    tick();
    iv[0] = 1'b0;
    tick();
    iv[0] = 1'b1;
    id[0] = W'(8'hA2);
    tick();
    id[0] = W'(8'hA3);
    tick();
    id[0] = W'(8'hA4);
    #1;
    nvec++;
    if (cnt[0] !== 3 || od[0] !== W'(8'hA1) || irdy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL stall_full: count=%0d data=%h in_ready=%b, want 3 a1 0", cnt[0], od[0], irdy[0]);
    end
    tick();
    tick();
    nvec++;
    if (cnt[0] !== 3 || od[0] !== W'(8'hA1) || irdy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL stall_hold: count=%0d data=%h in_ready=%b, want 3 a1 0", cnt[0], od[0], irdy[0]);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      #1;
      acc = iv[0] && irdy[0];
      if (ov[0]) got.push_back(od[0]);
      tick();
      if (acc) iv[0] = 1'b0;
    end
    ok = got.size() == 4;
    for (int i = 0; i < got.size() && i < 4; i++) ok = ok && got[i] === W'(8'hA1 + i);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL stall_order: received %0d bundles, first=%h, want a1 a2 a3 a4", got.size(), got.size() > 0 ? got[0] : '0);
    end
    nvec++;
    if (ov[0] !== 1'b0 || cnt[0] !== 0) begin
      nerr++;
      $display("FAIL stall_drained: valid=%b count=%0d, want 0 0", ov[0], cnt[0]);
    end
  endtask

  task automatic test_flush;
    ordy[1] = 1'b0;
    iv[1] = 1'b1;
    id[1] = W'(4'h5);
    tick();
    id[1] = W'(4'h6);
    tick();
    nvec++;
    if (cnt[1] !== 2 || od[1] !== W'(4'h5)) begin
      nerr++;
      $display("FAIL flush_fill: count=%0d data=%h, want 2 5", cnt[1], od[1]);
    end
    id[1] = W'(4'h7);
    flush = 1'b1;
    #1;
    nvec++;
    if (irdy[1] !== 1'b0) begin
      nerr++;
      $display("FAIL flush_in_ready: in_ready=%b, want 0", irdy[1]);
    end
    tick();
    flush = 1'b0;
    iv[1] = 1'b0;
    nvec++;
    if (cnt[1] !== 0 || ov[1] !== 1'b0 || od[1] !== '0) begin
      nerr++;
      $display("FAIL flush_empty: count=%0d valid=%b data=%h, want 0 0 0", cnt[1], ov[1], od[1]);
    end
    ordy[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++;
      if (ov[1] !== 1'b0) begin
        nerr++;
        $display("FAIL flush_no_ghost cycle%0d: valid=%b data=%h, want 0", c, ov[1], od[1]);
      end
    end
  endtask

  task automatic test_passthru;
    ordy[2] = 1'b0;
    iv[2] = 1'b1;
    id[2] = W'(4'h9);
    tick();
    nvec++;
    if (ov[2] !== 1'b1 || od[2] !== W'(4'h9) || cnt[2] !== 1) begin
      nerr++;
      $display("FAIL passthru_load: valid=%b data=%h count=%0d, want 1 9 1", ov[2], od[2], cnt[2]);
    end
    ordy[2] = 1'b1;
    id[2] = W'(4'hB);
    #1;
    nvec++;
    if (irdy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL passthru_ready: in_ready=%b, want 1", irdy[2]);
    end
    tick();
    iv[2] = 1'b0;
    nvec++;
    if (ov[2] !== 1'b1 || od[2] !== W'(4'hB) || cnt[2] !== 1) begin
      nerr++;
      $display("FAIL passthru_swap: valid=%b data=%h count=%0d, want 1 b 1", ov[2], od[2], cnt[2]);
    end
    tick();
  endtask

  task automatic test_zero_bubble;
    ordy[0] = 1'b1;
    ordy[3] = 1'b1;
    iv[0] = 1'b1;
    iv[3] = 1'b1;
    id[0] = W'(4'hC);
    id[3] = W'(4'hC);
    tick();
    iv[0] = 1'b0;
    iv[3] = 1'b0;
    tick();
    tick();
    nvec++;
    if (ov[0] !== 1'b1 || od[0] !== W'(4'hC) || ov[3] !== 1'b1 || od[3] !== W'(4'hC)) begin
      nerr++;
      $display("FAIL bubble_present: zb1 %b/%h zb0 %b/%h, want 1/c 1/c", ov[0], od[0], ov[3], od[3]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      nvec++;
      if (ov[3] !== 1'b0 || od[3] !== W'(4'hC)) begin
        nerr++;
        $display("FAIL bubble_stale cycle%0d: valid=%b data=%h, want 0 c", c, ov[3], od[3]);
      end
      nvec++;
      if (ov[0] !== 1'b0 || od[0] !== '0) begin
        nerr++;
        $display("FAIL bubble_zero cycle%0d: valid=%b data=%h, want 0 0", c, ov[0], od[0]);
      end
    end
  endtask

  task automatic test_random;
    logic pend [4];
    for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k]) begin
          iv[k] = $urandom_range(0, 3) != 0;
          id[k] = rnd();
        end
        ordy[k] = $urandom_range(0, 2) != 0;
      end
      flush = $urandom_range(0, 31) == 0;
      #1;
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (irdy[k] !== exp_rdy(k)) begin
          nerr++;
          $display("FAIL random_in_ready dut%0d cycle%0d: in_ready=%b, want %b", k, c, irdy[k], exp_rdy(k));
        end
        pend[k] = iv[k] && !exp_rdy(k);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (ov[k] !== mlast(k) || cnt[k] !== mcnt(k) || ((k != 3 || ov[k]) && od[k] !== mout(k))) begin
          nerr++;
          $display("FAIL random_out dut%0d cycle%0d: valid=%b count=%0d data=%h, want %b %0d %h", k, c, ov[k], cnt[k], od[k], mlast(k), mcnt(k), mout(k));
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0;
      id[k] = '0;
      ordy[k] = 1'b1;
    end
    model_clear();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_passthru();
    test_zero_bubble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
